reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
Architectural register file with per-register rename tags. It sits between issue and the reorder buffer.
- Issue reads source operand status (ready value or producing ROB entry) and marks the destination register busy with its ROB number.
- ROB commit writes retired results back and releases the tag.
- A misbranch flush clears all pending tags.

Parameters:
REG_NUM, 32, number of architectural registers (x0 hardwired zero)
DATA_W, 32, register data width (matches `Data_Len)
ROB_W, 4, ROB index width (matches `Rob_Addr_Len)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
rdy  input  1  global enable; state frozen when low
has_misbranch  input  1  flush pulse from ROB
issue_valid  input  1  an instruction with a destination register is issued this cycle
issue_dest  input  5  destination register of issued instruction
issue_rob_num  input  ROB_W  ROB entry assigned to issued instruction
rs1_addr  input  5  source 1 register index
rs2_addr  input  5  source 2 register index
rs1_busy  output  1  source 1 awaits an in-flight result
rs1_rob_num  output  ROB_W  producing ROB entry for rs1 (valid when busy)
rs1_data  output  DATA_W  rs1 value (valid when not busy)
rs2_busy  output  1  as rs1
rs2_rob_num  output  ROB_W  as rs1
rs2_data  output  DATA_W  as rs1
commit_valid  input  1  ROB retires a register write (has_to_reg)
commit_dest  input  5  retiring destination (dest_reg_num)
commit_data  input  DATA_W  retiring value (out_reg_data)
commit_rob_num  input  ROB_W  retiring ROB entry (out_reg_rob_num)

Behaviour:
- State per register: data[DATA_W], busy, tag[ROB_W].
- Reset: asynchronous to rst. All data = 0, busy = 0, tag = 0. Outputs are combinational from state, so after reset: rsX_busy = 0, rsX_data = 0, rsX_rob_num = 0.
- rdy low: no state update. Combinational reads and bypass still active.
- Read path (combinational, zero latency):
  - Index 0: always busy = 0, data = 0, rob_num = 0.
  - Otherwise busy/tag/data of the indexed register, with commit bypass.
  - Bypass applies when commit_valid && commit_dest == rsX_addr && commit_dest != 0 && busy[rsX] && tag[rsX] == commit_rob_num. Then busy = 0 and data = commit_data.
- Reads never see same-cycle issue_valid. An instruction reading and writing the same register gets the older producer.
- Clock edge (rdy high), order of effect:
  1. Commit: if commit_valid && commit_dest != 0, then data[dest] <= commit_data. If busy[dest] && tag[dest] == commit_rob_num, then busy[dest] <= 0. A tag mismatch means a younger writer owns the register; busy and tag stay unchanged.
  2. Misbranch: if has_misbranch, busy <= 0 for all registers. Tags are don't-care. The commit data write in the same cycle still lands, because the committed instruction is older than the branch.
  3. Issue: if issue_valid && !has_misbranch && issue_dest != 0, then busy[issue_dest] <= 1 and tag[issue_dest] <= issue_rob_num. This overrides a same-cycle commit release on the same register. Issue during misbranch is discarded.
- Writes to x0 are ignored everywhere.
- ROB wrap-around: tags compare by equality only. ROB guarantees no two live entries share a number.
- Reset mid-operation: all pending tags are lost. ROB and issue reset on the same rst.

Decomposition:
- Use `Reg_Addr_Len, `Rob_Addr_Len, `Data_Len, `True/`False from config.v. Add `Reg_Num (32) and `Zero_Reg (5'd0) there.
- One sub-module, reg_read_port, holds the read mux and commit-bypass logic and is instantiated twice (rs1, rs2).

Test Plan:
- Reset, then read x5 -> busy=0, data=0. Commit x5=0x1234 tag 3 (not busy) -> next-cycle read x5 data=0x1234, busy=0.
- Issue x7 tag 2; next cycle read x7 -> busy=1, rob_num=2. Commit x7=0xAA tag 2 -> same-cycle read busy=0, data=0xAA (bypass). Next cycle state busy=0.
- Issue x7 tag 2, then x7 tag 5. Commit x7 tag 2 data 0x11 -> data=0x11, busy stays 1, rob_num=5.
- Same cycle: commit x9 tag 4 (owner) and issue x9 tag 6 -> next cycle busy=1, rob_num=6, data=commit value.
- Issue x1, x2, x3 busy. Assert has_misbranch together with issue x4 tag 8 -> all busy=0, x4 not busy.
- Issue or commit to x0 with data 0xFFFFFFFF -> read x0 busy=0, data=0. Hold rdy=0 during a commit -> no state change. Assert rst asynchronously mid-run -> outputs go to 0 before the next clk edge.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared widths and constants for the architectural register file
// (register index, ROB index, data width, zero register).
package reg_file_pkg;

   localparam int REG_ADDR_LEN = 5;
   localparam int ROB_ADDR_LEN = 4;
   localparam int DATA_LEN     = 32;
   localparam int REG_NUM      = 32;

   localparam logic [REG_ADDR_LEN-1:0] ZERO_REG = 5'd0;
   localparam logic                    TRUE     = 1'b1;
   localparam logic                    FALSE    = 1'b0;

endpackage : reg_file_pkg

// File: rtl/reg_file_read_port.sv
// One combinational read port: selects the register's busy/tag/data
// and forwards a same-cycle commit from the owning ROB entry.
module reg_read_port
   import reg_file_pkg::*;
#(
   parameter int REG_NUM = reg_file_pkg::REG_NUM,
   parameter int DATA_W  = DATA_LEN,
   parameter int ROB_W   = ROB_ADDR_LEN
) (
   input  logic [REG_ADDR_LEN-1:0]        addr,
   input  logic [REG_NUM-1:0]             busy_all,
   input  logic [REG_NUM-1:0][ROB_W-1:0]  tag_all,
   input  logic [REG_NUM-1:0][DATA_W-1:0] data_all,
   input  logic                           commit_valid,
   input  logic [REG_ADDR_LEN-1:0]        commit_dest,
   input  logic [DATA_W-1:0]              commit_data,
   input  logic [ROB_W-1:0]               commit_rob_num,
   output logic                           busy,
   output logic [ROB_W-1:0]               rob_num,
   output logic [DATA_W-1:0]              data
);

   always_comb begin
      busy    = FALSE;
      rob_num = '0;
      data    = '0;
      if (addr != ZERO_REG) begin
         busy    = busy_all[addr];
         rob_num = tag_all[addr];
         data    = data_all[addr];
         // only the ROB entry that currently owns the register may release it
         if (commit_valid && commit_dest == addr && busy_all[addr] &&
             tag_all[addr] == commit_rob_num) begin
            busy = FALSE;
            data = commit_data;
         end
      end
   end

endmodule : reg_read_port

// File: rtl/reg_file.sv
// Architectural register file with rename tags: issue marks destinations
// busy, ROB commit writes back and releases, misbranch clears all busy bits.
module reg_file
   import reg_file_pkg::*;
#(
   parameter int REG_NUM = reg_file_pkg::REG_NUM,
   parameter int DATA_W  = DATA_LEN,
   parameter int ROB_W   = ROB_ADDR_LEN
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    rdy,
   input  logic                    has_misbranch,
   input  logic                    issue_valid,
   input  logic [REG_ADDR_LEN-1:0] issue_dest,
   input  logic [ROB_W-1:0]        issue_rob_num,
   input  logic [REG_ADDR_LEN-1:0] rs1_addr,
   input  logic [REG_ADDR_LEN-1:0] rs2_addr,
   output logic                    rs1_busy,
   output logic [ROB_W-1:0]        rs1_rob_num,
   output logic [DATA_W-1:0]       rs1_data,
   output logic                    rs2_busy,
   output logic [ROB_W-1:0]        rs2_rob_num,
   output logic [DATA_W-1:0]       rs2_data,
   input  logic                    commit_valid,
   input  logic [REG_ADDR_LEN-1:0] commit_dest,
   input  logic [DATA_W-1:0]       commit_data,
   input  logic [ROB_W-1:0]        commit_rob_num
);

   logic [REG_NUM-1:0]             busy_q;
   logic [REG_NUM-1:0][ROB_W-1:0]  tag_q;
   logic [REG_NUM-1:0][DATA_W-1:0] data_q;

   logic commit_hit;
   logic issue_hit;

   assign commit_hit = commit_valid && (commit_dest != ZERO_REG);
   assign issue_hit  = issue_valid && !has_misbranch && (issue_dest != ZERO_REG);

   // Later non-blocking writes win: misbranch and issue override a commit release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= '0;
         tag_q  <= '0;
         data_q <= '0;
      end else if (rdy) begin
         if (commit_hit) begin
            data_q[commit_dest] <= commit_data;
            if (busy_q[commit_dest] && tag_q[commit_dest] == commit_rob_num)
               busy_q[commit_dest] <= FALSE;
         end
         if (has_misbranch)
            busy_q <= '0;
         if (issue_hit) begin
            busy_q[issue_dest] <= TRUE;
            tag_q[issue_dest]  <= issue_rob_num;
         end
      end
   end

   reg_read_port #(.REG_NUM(REG_NUM), .DATA_W(DATA_W), .ROB_W(ROB_W)) u_rs1 (
      .addr           (rs1_addr),
      .busy_all       (busy_q),
      .tag_all        (tag_q),
      .data_all       (data_q),
      .commit_valid   (commit_valid),
      .commit_dest    (commit_dest),
      .commit_data    (commit_data),
      .commit_rob_num (commit_rob_num),
      .busy           (rs1_busy),
      .rob_num        (rs1_rob_num),
      .data           (rs1_data)
   );

   reg_read_port #(.REG_NUM(REG_NUM), .DATA_W(DATA_W), .ROB_W(ROB_W)) u_rs2 (
      .addr           (rs2_addr),
      .busy_all       (busy_q),
      .tag_all        (tag_q),
      .data_all       (data_q),
      .commit_valid   (commit_valid),
      .commit_dest    (commit_dest),
      .commit_data    (commit_data),
      .commit_rob_num (commit_rob_num),
      .busy           (rs2_busy),
      .rob_num        (rs2_rob_num),
      .data           (rs2_data)
   );

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Bench for reg_file: directed scenarios then random issue/commit/flush
// traffic, compared against an array-based model of the register state.
module tb_reg_file;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic        has_misbranch;
   logic        issue_valid;
   logic [4:0]  issue_dest;
   logic [3:0]  issue_rob_num;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic        rs1_busy;
   logic [3:0]  rs1_rob_num;
   logic [31:0] rs1_data;
   logic        rs2_busy;
   logic [3:0]  rs2_rob_num;
   logic [31:0] rs2_data;
   logic        commit_valid;
   logic [4:0]  commit_dest;
   logic [31:0] commit_data;
   logic [3:0]  commit_rob_num;

   int errors = 0;
   int checks = 0;

   logic [31:0] m_data [32];
   logic        m_busy [32];
   logic [3:0]  m_tag  [32];

   reg_file dut (
      .clk            (clk),
      .rst            (rst),
      .rdy            (rdy),
      .has_misbranch  (has_misbranch),
      .issue_valid    (issue_valid),
      .issue_dest     (issue_dest),
      .issue_rob_num  (issue_rob_num),
      .rs1_addr       (rs1_addr),
      .rs2_addr       (rs2_addr),
      .rs1_busy       (rs1_busy),
      .rs1_rob_num    (rs1_rob_num),
      .rs1_data       (rs1_data),
      .rs2_busy       (rs2_busy),
      .rs2_rob_num    (rs2_rob_num),
      .rs2_data       (rs2_data),
      .commit_valid   (commit_valid),
      .commit_dest    (commit_dest),
      .commit_data    (commit_data),
      .commit_rob_num (commit_rob_num)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 32; i++) begin
         m_data[i] = '0;
         m_busy[i] = 1'b0;
         m_tag[i]  = '0;
      end
   endtask

   // Expected read: the register's stored view, unless the owner commits right now.
   task automatic expect_read(input logic [4:0] a, output logic b, output logic [3:0] t,
                              output logic [31:0] d);
      b = 1'b0; t = '0; d = '0;
      if (a != 5'd0) begin
         b = m_busy[a]; t = m_tag[a]; d = m_data[a];
         if (commit_valid && commit_dest == a && b && t == commit_rob_num) begin
            b = 1'b0;
            d = commit_data;
         end
      end
   endtask

   task automatic check_ports(input string tag);
      logic        b;
      logic [3:0]  t;
      logic [31:0] d;
      expect_read(rs1_addr, b, t, d);
      chk({tag, ".rs1_busy"}, 32'(rs1_busy), 32'(b));
      chk({tag, ".rs1_data"}, rs1_data, d);
      if (b) chk({tag, ".rs1_rob"}, 32'(rs1_rob_num), 32'(t));
      expect_read(rs2_addr, b, t, d);
      chk({tag, ".rs2_busy"}, 32'(rs2_busy), 32'(b));
      chk({tag, ".rs2_data"}, rs2_data, d);
      if (b) chk({tag, ".rs2_rob"}, 32'(rs2_rob_num), 32'(t));
   endtask

   task automatic idle();
      has_misbranch = 1'b0;
      issue_valid   = 1'b0;
      issue_dest    = '0;
      issue_rob_num = '0;
      commit_valid  = 1'b0;
      commit_dest   = '0;
      commit_data   = '0;
      commit_rob_num = '0;
   endtask

   // Clock edge: commit lands, then flush clears, then a surviving issue claims.
   task automatic step();
      @(posedge clk);
      if (rdy) begin
         if (commit_valid && commit_dest != 5'd0) begin
            m_data[commit_dest] = commit_data;
            if (m_busy[commit_dest] && m_tag[commit_dest] == commit_rob_num)
               m_busy[commit_dest] = 1'b0;
         end
         if (has_misbranch) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
         end else if (issue_valid && issue_dest != 5'd0) begin
            m_busy[issue_dest] = 1'b1;
            m_tag[issue_dest]  = issue_rob_num;
         end
      end
      #1;
   endtask

   task automatic do_issue(input logic [4:0] r, input logic [3:0] t);
      idle(); issue_valid = 1'b1; issue_dest = r; issue_rob_num = t;
      step();
   endtask

   initial begin
      rst = 1'b1; rdy = 1'b1; idle();
      rs1_addr = 5'd5; rs2_addr = 5'd0;
      model_clear();
      #2;
      check_ports("reset");
      chk("reset.rs1_rob", 32'(rs1_rob_num), 32'd0);
      chk("reset.rs2_rob", 32'(rs2_rob_num), 32'd0);
      #8 rst = 1'b0;
      #1;

      // commit to a non-busy register just writes data
      commit_valid = 1'b1; commit_dest = 5'd5; commit_data = 32'h1234; commit_rob_num = 4'd3;
      #1 check_ports("commit_idle_same");
      step(); idle();
      chk("commit_idle.data", rs1_data, 32'h1234);
      chk("commit_idle.busy", 32'(rs1_busy), 32'd0);

      // issue then bypassed commit
      do_issue(5'd7, 4'd2); idle();
      rs1_addr = 5'd7;
      #1 chk("issue.busy", 32'(rs1_busy), 32'd1);
      chk("issue.rob", 32'(rs1_rob_num), 32'd2);
      commit_valid = 1'b1; commit_dest = 5'd7; commit_data = 32'hAA; commit_rob_num = 4'd2;
      #1 chk("bypass.busy", 32'(rs1_busy), 32'd0);
      chk("bypass.data", rs1_data, 32'hAA);
      step(); idle();
      #1 chk("after_commit.busy", 32'(rs1_busy), 32'd0);

      // older commit must not release a younger writer
      do_issue(5'd7, 4'd2);
      do_issue(5'd7, 4'd5);
      idle(); commit_valid = 1'b1; commit_dest = 5'd7; commit_data = 32'h11; commit_rob_num = 4'd2;
      step(); idle();
      #1 chk("younger.data", rs1_data, 32'h11);
      chk("younger.busy", 32'(rs1_busy), 32'd1);
      chk("younger.rob", 32'(rs1_rob_num), 32'd5);

      // same-cycle owner commit and new issue
      do_issue(5'd9, 4'd4);
      idle(); commit_valid = 1'b1; commit_dest = 5'd9; commit_data = 32'h5A5A; commit_rob_num = 4'd4;
      issue_valid = 1'b1; issue_dest = 5'd9; issue_rob_num = 4'd6;
      step(); idle();
      rs2_addr = 5'd9;
      #1 chk("commit_issue.busy", 32'(rs2_busy), 32'd1);
      chk("commit_issue.rob", 32'(rs2_rob_num), 32'd6);
      chk("commit_issue.data", rs2_data, 32'h5A5A);

      // misbranch flush drops same-cycle issue
      do_issue(5'd1, 4'd1);
      do_issue(5'd2, 4'd3);
      do_issue(5'd3, 4'd7);
      idle(); has_misbranch = 1'b1; issue_valid = 1'b1; issue_dest = 5'd4; issue_rob_num = 4'd8;
      step(); idle();
      for (int r = 1; r <= 4; r++) begin
         rs1_addr = 5'(r);
         #1 chk($sformatf("flush.x%0d", r), 32'(rs1_busy), 32'd0);
      end

      // x0 is immutable
      idle(); issue_valid = 1'b1; issue_dest = 5'd0; issue_rob_num = 4'd1;
      commit_valid = 1'b1; commit_dest = 5'd0; commit_data = 32'hFFFFFFFF; commit_rob_num = 4'd1;
      rs1_addr = 5'd0;
      #1 check_ports("x0_same");
      step(); idle();
      #1 chk("x0.busy", 32'(rs1_busy), 32'd0);
      chk("x0.data", rs1_data, 32'd0);

      // rdy low freezes state
      rdy = 1'b0;
      commit_valid = 1'b1; commit_dest = 5'd5; commit_data = 32'hDEAD; commit_rob_num = 4'd0;
      issue_valid = 1'b1; issue_dest = 5'd6; issue_rob_num = 4'd3;
      step(); idle(); rdy = 1'b1;
      rs1_addr = 5'd5; rs2_addr = 5'd6;
      #1 chk("frozen.data", rs1_data, 32'h1234);
      chk("frozen.busy", 32'(rs2_busy), 32'd0);

      // random traffic on a small register window to force collisions
      for (int n = 0; n < 400; n++) begin
         idle();
         rdy           = ($urandom_range(0, 7) != 0);
         has_misbranch = ($urandom_range(0, 24) == 0);
         issue_valid   = ($urandom_range(0, 1) == 1);
         issue_dest    = 5'($urandom_range(0, 7));
         issue_rob_num = 4'($urandom_range(0, 15));
         commit_valid  = ($urandom_range(0, 1) == 1);
         commit_dest   = 5'($urandom_range(0, 7));
         commit_data   = $urandom;
         commit_rob_num = ($urandom_range(0, 1) == 1) ? m_tag[commit_dest]
                                                      : 4'($urandom_range(0, 15));
         rs1_addr = ($urandom_range(0, 2) == 0) ? commit_dest : 5'($urandom_range(0, 7));
         rs2_addr = 5'($urandom_range(0, 7));
         #1 check_ports($sformatf("rand%0d", n));
         step();
      end

      // asynchronous reset between edges
      idle(); rdy = 1'b1;
      commit_valid = 1'b1; commit_dest = 5'd3; commit_data = 32'hCAFE; commit_rob_num = 4'd0;
      step();
      do_issue(5'd4, 4'd9); idle();
      rs1_addr = 5'd3; rs2_addr = 5'd4;
      #1 check_ports("pre_rst");
      rst = 1'b1;
      model_clear();
      #1 chk("async_rst.rs1_data", rs1_data, 32'd0);
      chk("async_rst.rs1_busy", 32'(rs1_busy), 32'd0);
      chk("async_rst.rs2_busy", 32'(rs2_busy), 32'd0);
      chk("async_rst.rs2_rob", 32'(rs2_rob_num), 32'd0);
      #2 rst = 1'b0;
      step();
      check_ports("post_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_reg_file
